// File: rtl/demux_n_reg_if.sv
// Stream bundle for demux_n_reg: one producer port in, NCH consumer channels out,
// plus drop flag and the optional per-channel transfer counters.
interface demux_n_reg_if #(
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int DW   = 8,
  parameter int CNTW = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [SELW-1:0]     in_sel;
  logic [DW-1:0]       in_data;
  logic [NCH-1:0]      out_valid;
  logic [NCH-1:0]      out_ready;
  logic [NCH*DW-1:0]   out_data;
  logic                err_drop;
  logic                cnt_clr;
  logic [NCH*CNTW-1:0] cnt_flat;

  modport master (
    output in_valid, in_sel, in_data, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, err_drop, cnt_flat
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, err_drop, cnt_flat
  );
endinterface

// File: rtl/demux_n_reg.sv
// Registered 1-to-NCH demultiplexer with valid/ready flow control and a one-word holding stage.
// Define DEMUX_CNT_EN to build saturating per-channel delivered-word counters.
module demux_n_reg #(
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input logic           clk,
  input logic           rst_n,
  demux_n_reg_if.slave  bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  state_t          state_q, state_d;
  logic [SELW-1:0] hold_sel_p0;
  logic [DW-1:0]   hold_data_p0;
  logic            err_p0;

  logic [NCH-1:0]    sel_hit;
  logic [NCH-1:0]    vld;
  logic [NCH*DW-1:0] data_flat;
  logic              fire, accept, in_range;
  logic              load, clr_data, err_d;

  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NCH; i++) sel_hit[i] = (hold_sel_p0 == SELW'(i));
  end

  // Only the selected channel's ready matters; others are masked off by sel_hit.
  assign fire         = (state_q == FULL) && |(sel_hit & bus.out_ready);
  assign bus.in_ready = (state_q == EMPTY) || |(sel_hit & bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_range     = ({1'b0, bus.in_sel} < NCH_L);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    clr_data = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (in_range) begin
            state_d = FULL;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (fire) begin
          if (accept && in_range) begin
            load = 1'b1;
          end else begin
            state_d  = EMPTY;
            clr_data = 1'b1;
            err_d    = accept;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stage p0: holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      hold_sel_p0  <= '0;
      hold_data_p0 <= '0;
      err_p0       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_p0  <= err_d;
      if (load) begin
        hold_sel_p0  <= bus.in_sel;
        hold_data_p0 <= bus.in_data;
      end else if (clr_data) begin
        hold_data_p0 <= '0;
      end
    end
  end

  always_comb begin
    vld       = '0;
    data_flat = '0;
    for (int i = 0; i < NCH; i++) begin
      vld[i] = (state_q == FULL) && sel_hit[i];
      data_flat[i*DW +: DW] = vld[i] ? hold_data_p0 : '0;
    end
  end

  assign bus.out_valid = vld;
  assign bus.out_data  = data_flat;
  assign bus.err_drop  = err_p0;

`ifdef DEMUX_CNT_EN
  logic [CNTW-1:0]     cnt_q [NCH];
  logic [NCH*CNTW-1:0] cnt_flat_w;

  // Clear wins over a same-edge increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.cnt_clr)
          cnt_q[i] <= '0;
        else if (fire && sel_hit[i] && (cnt_q[i] != {CNTW{1'b1}}))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    cnt_flat_w = '0;
    for (int i = 0; i < NCH; i++) cnt_flat_w[i*CNTW +: CNTW] = cnt_q[i];
  end

  assign bus.cnt_flat = cnt_flat_w;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.cnt_flat   = '0;
`endif
endmodule

// File: doc/demux_n_reg.md
Name: demux_n_reg

Overview:
- Parametrised, registered 1-to-NCH demultiplexer with valid/ready flow control; generalises the team's 4-way gate-level demux to arbitrary width and channel count.
- A single input stream carries data plus a channel select. Each accepted word is held in a one-entry output register and presented only on the selected channel.
- Unselected channels always drive data 0 and valid 0.
- Sits between a shared producer and NCH independent consumers.

Parameters:
NCH, 4, number of output channels (2..16)
SELW, 2, select width; must satisfy 2**SELW >= NCH
DW, 8, data width per channel
CNTW, 8, width of per-channel transfer counters (optional feature)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word this cycle
in_sel  input  SELW  destination channel, sampled with in_valid
in_data  input  DW  input word
out_valid  output  NCH  bit i: channel i holds a word
out_ready  input  NCH  bit i: consumer i accepts
out_data  output  NCH*DW  channel i at bits [i*DW +: DW]; 0 when not valid
err_drop  output  1  one-cycle pulse: word with in_sel >= NCH was dropped
cnt_clr  input  1  synchronous clear of transfer counters (optional feature)
cnt_flat  output  NCH*CNTW  per-channel delivered-word counters (optional feature)

Behaviour:
- Reset, asynchronous with rst_n = 0, forces:
  - state EMPTY;
  - hold_sel = 0, hold_data = 0;
  - out_valid = 0, out_data = 0, err_drop = 0, counters = 0.
- Reset asserted mid-transfer discards the held word. Nothing is replayed after release.
- Two-state FSM:
  - EMPTY: no word held; out_valid = 0.
  - FULL: word held; out_valid[hold_sel] = 1; all other bits 0.
- in_ready = (state == EMPTY) || out_ready[hold_sel]. It is combinational from out_ready; there is no combinational path from in_valid.
- Input accept: in_valid && in_ready at a rising edge.
- Output fire: state == FULL && out_ready[hold_sel] at a rising edge.
- Transitions:
  - EMPTY + accept of in-range word -> FULL; hold_sel, hold_data loaded.
  - FULL + fire, no accept -> EMPTY; hold_data cleared to 0.
  - FULL + fire + accept of in-range word -> stays FULL with the new word. This gives back-to-back throughput of 1 word/cycle, including channel switches.
  - FULL, no fire -> hold all; in_ready = 0. out_valid and out_data must stay stable until fired.
  - Accept of out-of-range word (in_sel >= NCH):
    - word is discarded and err_drop = 1 on the next cycle;
    - state becomes EMPTY if a fire occurred that cycle, otherwise unchanged.
- Latency: word accepted at edge k is visible on its channel after edge k (1 cycle).
- out_data for channel i = hold_data when out_valid[i], else 0. All outputs are registered or decoded from registers only.
- out_ready bits for non-selected channels are ignored.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Each channel has a CNTW-bit counter, incremented on every fire to that channel.
  - Counters saturate at 2**CNTW-1 and do not wrap.
  - cnt_clr = 1 zeroes all counters on the next edge; clear has priority over a same-cycle increment.
  - cnt_flat channel i occupies bits [i*CNTW +: CNTW].
- Not defined: cnt_flat is tied to 0, cnt_clr is ignored, and no counter flops are built.

Test Plan:
- Reset: rst_n = 0 with in_valid = 1, in_sel = 1, in_data = 8'hA5 -> out_valid = 4'b0000, out_data = 0, in_ready = 1, err_drop = 0.
- Single word: in_sel = 2, in_data = 8'h3C, out_ready = 4'b1111 -> next cycle out_valid = 4'b0100, channel 2 data = 8'h3C, channels 0/1/3 = 0; then EMPTY.
- Back-pressure: in_sel = 1, in_data = 8'h11, out_ready[1] = 0 for 5 cycles while in_valid stays 1 -> in_ready = 0, channel 1 holds 8'h11 stable. Raising out_ready[1] fires it, with next word accepted same edge.
- Streaming: sel sequence 0,1,2,3,0 with data 1..5, all out_ready = 1 -> one word per cycle; out_valid sequence 0001,0010,0100,1000,0001.
- Out-of-range: NCH = 3, SELW = 2, in_sel = 3, in_data = 8'hFF -> err_drop pulses 1 cycle, out_valid stays 0, counters unchanged.
- DEMUX_CNT_EN with CNTW = 2: 5 fires to channel 0 -> count saturates at 3. cnt_clr in same cycle as a fire -> count 0.
